cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception controller for the 5-stage MIPS pipeline, located in the M stage.
- Detects interrupts and exceptions and raises the one-cycle redirect request consumed by the next-PC logic. That logic then vectors to 32'h0000_4180.
- Holds SR, Cause, EPC and PRId. Serves mfc0/mtc0 and supplies EPC for eret.

Parameters:
- PRID, 32'h2020_0707, read-only processor ID value returned for register 15.
- HANDLER, 32'h0000_4180, informational only: documents the vector; not used in logic.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable (M stage)
- PC_M  input  32  PC of the instruction in M
- BD_M  input  1  M instruction is in a branch delay slot
- ExcCode_M  input  5  pending exception code of M instruction; 0 = none
- HWInt  input  6  external interrupt lines [7:2]
- EXLClr  input  1  eret in M: clear SR.EXL
- Req  output  1  redirect request to the next-PC logic (combinational)
- EPC_out  output  32  current EPC, for eret redirect
- DOut  output  32  mfc0 read data (combinational)

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits, bits[1:0] always 0.
  - PRId (15): PRID.
  - Any other A1 reads 0.
- Reset (asynchronous, immediate): SR, Cause and EPC all become 0. Outputs during reset: Req=0, EPC_out=0, DOut follows A1 (PRId still readable).
- Request logic:
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
  - ExcReq = (ExcCode_M != 0) & ~SR.EXL
  - Req = IntReq | ExcReq, same cycle, zero latency.
- On a rising edge with Req=1:
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCode_M. An interrupt beats a simultaneous exception.
  - Cause.BD <= BD_M.
  - EPC <= {(BD_M ? PC_M-4 : PC_M)[31:2], 2'b00}.
  - A concurrent mtc0 (WE) is discarded. The faulting instruction does not commit.
- On a rising edge with Req=0:
  - WE writes A2 ∈ {12,14}: SR field bits only, or EPC with bits[1:0] cleared.
  - Writes to 13, 15 or other numbers are ignored.
  - EXLClr clears EXL. If EXLClr and a WE to SR coincide, EXLClr wins for the EXL bit.
- Cause.IP <= HWInt on every non-reset edge, regardless of Req.
- Req cannot coincide with EXLClr while EXL=1, because EXL masks Req. If EXL=0, an eret carrying an exception takes Req.
- Nested events: while EXL=1, every request is masked. Pending HWInt remains visible in IP and fires on the first cycle after EXL clears, provided IE and IM permit.
- Arithmetic: PC_M-4 is 32-bit modular; wraps at 0.

Optional Feature:
- Macro CP0_EPC_BYPASS_EN.
- Defined: when WE=1, A2=14 and Req=0, EPC_out presents {DIn[31:2],2'b00} in the same cycle, so an mtc0 EPC directly followed by eret needs no stall.
- Undefined: EPC_out is the registered EPC only, and the hazard unit must stall eret behind an mtc0 EPC.

Decomposition:
- Shared package/header, alongside the existing constant include:
  - CP0 register numbers: SR=12, Cause=13, EPC=14, PRId=15.
  - ExcCode values: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - SR/Cause bit-field positions.
  - Handler address 32'h0000_4180.
- One natural sub-module: cp0_req_gen, the combinational IntReq/ExcReq/priority logic.

Test Plan:
- Reset mid-run with EXL=1, EPC=0x3010 -> all registers 0 immediately; Req=0.
- mtc0 SR=0x0000_0401, HWInt=6'b000001 -> Req=1 the same cycle. Next edge: EXL=1, Cause.ExcCode=0, EPC=PC_M (e.g. 0x3008). Req then 0.
- ExcCode_M=12 (Ov), PC_M=0x3020, BD_M=1 -> Req=1; EPC=0x301C, Cause.BD=1, Cause.ExcCode=12.
- Interrupt and ExcCode_M=10 in the same cycle -> ExcCode latched 0; EPC=PC_M.
- EXL=1 with ExcCode_M=4 and HWInt active -> Req=0. EXLClr pulse -> next cycle Req=1 if the interrupt is still enabled.
- mtc0 EPC=0x0000_3003 while Req=1 -> write ignored. Without Req -> EPC reads 0x3000. With CP0_EPC_BYPASS_EN, EPC_out=0x3000 in the write cycle.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes, SR/Cause field positions.
// Imported by cp0_req_gen and cp0_exc_ctrl.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  // EPC always holds a word-aligned address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational interrupt/exception request generation and cause priority.
// An interrupt outranks a simultaneous exception; EXL masks everything.
module cp0_req_gen
  import cp0_exc_ctrl_pkg::*;
(
  input  logic       reset,
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code,
  output logic       req,
  output logic [4:0] exc_code_sel
);

  logic [5:0] pending;
  logic       int_req;
  logic       exc_req;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mask
      assign pending[gi] = hw_int[gi] & im[gi];
    end
  endgenerate

  // Reset gates the request so a stale ExcCode cannot redirect while in reset.
  assign int_req      = ~reset & (|pending) & ie & ~exl;
  assign exc_req      = ~reset & (exc_code != EXC_INT) & ~exl;
  assign req          = int_req | exc_req;
  assign exc_code_sel = int_req ? EXC_INT : exc_code;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller (M stage): SR, Cause, EPC, PRId, redirect request.
// Optional macro CP0_EPC_BYPASS_EN forwards an mtc0 EPC write straight onto EPC_out.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2020_0707,
  parameter logic [31:0] HANDLER = HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic [4:0]  exc_code_next;
  logic [31:0] epc_trap;
  logic        wr_sr;
  logic        wr_epc;

  cp0_req_gen u_req_gen (
    .reset        (reset),
    .hw_int       (HWInt),
    .im           (im_reg),
    .ie           (ie_reg),
    .exl          (exl_reg),
    .exc_code     (ExcCode_M),
    .req          (Req),
    .exc_code_sel (exc_code_next)
  );

  // A delay-slot fault restarts at the branch; subtraction wraps modulo 2^32.
  assign epc_trap = word_align(BD_M ? (PC_M - 32'd4) : PC_M);
  assign wr_sr    = WE & ~Req & (A2 == CP0_REG_SR);
  assign wr_epc   = WE & ~Req & (A2 == CP0_REG_EPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      ip_reg <= HWInt;
      if (Req) begin
        exl_reg      <= 1'b1;
        exc_code_reg <= exc_code_next;
        bd_reg       <= BD_M;
        epc_reg      <= epc_trap;
      end else begin
        if (wr_sr) begin
          im_reg  <= DIn[SR_IM_MSB:SR_IM_LSB];
          ie_reg  <= DIn[SR_IE_BIT];
          exl_reg <= DIn[SR_EXL_BIT] & ~EXLClr;
        end else if (EXLClr) begin
          exl_reg <= 1'b0;
        end
        if (wr_epc) begin
          epc_reg <= word_align(DIn);
        end
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (A1)
      CP0_REG_SR:    DOut = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
      CP0_REG_CAUSE: DOut = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
      CP0_REG_EPC:   DOut = epc_reg;
      CP0_REG_PRID:  DOut = PRID;
      default:       DOut = '0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign EPC_out = (WE && !Req && !reset && (A2 == CP0_REG_EPC)) ? word_align(DIn) : epc_reg;
`else
  assign EPC_out = epc_reg;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a word-level register model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID_V = 32'h2020_0707;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Model state: architectural register words as software would see them.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .PC_M      (PC_M),
    .BD_M      (BD_M),
    .ExcCode_M (ExcCode_M),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .Req       (Req),
    .EPC_out   (EPC_out),
    .DOut      (DOut)
  );

  always #5 clk = ~clk;

  function automatic logic m_int_req();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    if (reset) return 1'b0;
    return m_int_req() || ((ExcCode_M != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_dout();
    case (A1)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    if (reset) return 32'd0;
`ifdef CP0_EPC_BYPASS_EN
    if (WE && A2 == 5'd14 && !m_req()) return DIn & 32'hFFFF_FFFC;
`endif
    return m_epc;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sr    <= 32'd0;
      m_cause <= 32'd0;
      m_epc   <= 32'd0;
    end else if (m_req()) begin
      m_sr    <= m_sr | 32'h0000_0002;
      m_cause <= {BD_M, 15'd0, HWInt, 3'd0, (m_int_req() ? 5'd0 : ExcCode_M), 2'd0};
      m_epc   <= (BD_M ? (PC_M - 32'd4) : PC_M) & 32'hFFFF_FFFC;
    end else begin
      m_cause <= {m_cause[31:16], HWInt, m_cause[9:0]};
      if (WE && A2 == 5'd12)
        m_sr <= (DIn & 32'h0000_FC03) & (EXLClr ? 32'hFFFF_FFFD : 32'hFFFF_FFFF);
      else if (EXLClr)
        m_sr <= m_sr & 32'hFFFF_FFFD;
      if (WE && A2 == 5'd14)
        m_epc <= DIn & 32'hFFFF_FFFC;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_req", {31'd0, Req}, {31'd0, m_req()});
      check("cyc_epc_out", EPC_out, m_epc_out());
      check("cyc_dout", DOut, m_dout());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; A2 = 5'd0; DIn = 32'd0; BD_M = 1'b0;
    ExcCode_M = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [4:0] a1, input logic [31:0] exp);
    A1 = a1;
    #1;
    check(nm, DOut, exp);
  endtask

  logic [4:0] a2_tab [7];
  logic [4:0] exc_tab [5];

  initial begin
    a2_tab  = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd12, 5'd14};
    exc_tab = '{5'd4, 5'd5, 5'd10, 5'd12, 5'd31};
    reset = 1'b1; A1 = 5'd0; PC_M = 32'd0;
    idle();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state with a pending exception code: request must stay low.
    ExcCode_M = 5'd4;
    chk_reg("rst_prid", 5'd15, PRID_V);
    check("rst_req", {31'd0, Req}, 32'd0);
    chk_reg("rst_sr", 5'd12, 32'd0);
    check("rst_epc_out", EPC_out, 32'd0);
    ExcCode_M = 5'd0;
    reset = 1'b0;
    tick();

    // Enable interrupt line 0, then raise it.
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle(); HWInt = 6'b000001; PC_M = 32'h3008;
    #1 check("int_req", {31'd0, Req}, 32'd1);
    tick();
    idle();
    chk_reg("int_sr", 5'd12, 32'h0000_0403);
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    chk_reg("int_epc", 5'd14, 32'h0000_3008);

    // EXL masks both exception and interrupt; EXLClr unmasks.
    tick();
    ExcCode_M = 5'd4; HWInt = 6'b000001;
    #1 check("masked_req", {31'd0, Req}, 32'd0);
    EXLClr = 1'b1;
    tick();
    idle(); HWInt = 6'b000001; PC_M = 32'h3010;
    #1 check("unmask_req", {31'd0, Req}, 32'd1);
    tick();
    idle(); EXLClr = 1'b1;
    chk_reg("unmask_epc", 5'd14, 32'h0000_3010);

    // Overflow in a delay slot.
    tick();
    idle(); ExcCode_M = 5'd12; PC_M = 32'h3020; BD_M = 1'b1;
    #1 check("ov_req", {31'd0, Req}, 32'd1);
    tick();
    idle();
    chk_reg("ov_epc", 5'd14, 32'h0000_301C);
    chk_reg("ov_cause", 5'd13, 32'h8000_0030);
    EXLClr = 1'b1;

    // Interrupt beats a simultaneous RI.
    tick();
    idle(); HWInt = 6'b000001; ExcCode_M = 5'd10; PC_M = 32'h3040;
    #1 check("pri_req", {31'd0, Req}, 32'd1);
    tick();
    idle();
    chk_reg("pri_cause", 5'd13, 32'h0000_0400);
    chk_reg("pri_epc", 5'd14, 32'h0000_3040);
    EXLClr = 1'b1;

    // mtc0 EPC discarded under Req, accepted otherwise.
    tick();
    idle(); WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3003; ExcCode_M = 5'd5; PC_M = 32'h3050;
    #1 check("wr_req", {31'd0, Req}, 32'd1);
    tick();
    idle();
    chk_reg("wr_discard", 5'd14, 32'h0000_3050);
    EXLClr = 1'b1;
    tick();
    idle(); WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3003;
`ifdef CP0_EPC_BYPASS_EN
    #1 check("wr_bypass", EPC_out, 32'h0000_3000);
`else
    #1 check("wr_nobypass", EPC_out, 32'h0000_3050);
`endif
    tick();
    idle();
    chk_reg("wr_epc", 5'd14, 32'h0000_3000);
    check("wr_epc_out", EPC_out, 32'h0000_3000);

    // Delay-slot PC of 0 wraps.
    tick();
    idle(); ExcCode_M = 5'd4; PC_M = 32'd0; BD_M = 1'b1;
    #1 check("wrap_req", {31'd0, Req}, 32'd1);
    tick();
    idle();
    chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    chk_reg("wrap_cause", 5'd13, 32'h8000_0010);

    // Asynchronous reset mid-run with EXL=1.
    tick();
    idle(); ExcCode_M = 5'd4;
    reset = 1'b1;
    chk_reg("amid_sr", 5'd12, 32'd0);
    check("amid_req", {31'd0, Req}, 32'd0);
    chk_reg("amid_epc", 5'd14, 32'd0);
    ExcCode_M = 5'd0;
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      A1     = 5'($urandom_range(10, 16));
      A2     = a2_tab[$urandom_range(0, 6)];
      DIn    = $urandom;
      WE     = ($urandom_range(0, 3) == 0);
      PC_M   = $urandom;
      BD_M   = 1'($urandom_range(0, 1));
      HWInt  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      ExcCode_M = ($urandom_range(0, 3) == 0) ? exc_tab[$urandom_range(0, 4)] : 5'd0;
      EXLClr = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
